// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - operand width and iteration counter width
//   - sequencer state encoding
//   - latency constants (edges from the accepting edge, inclusive, to the
//     edge after which data_resultRDY is high)
//   - Booth select encoding and decoder
//   - two's-complement magnitude helper used on the accepting edge of a divide
// -----------------------------------------------------------------------------
package multdiv_pkg;

  localparam int WIDTH    = 32;
  localparam int CNT_W    = 5;
  localparam int MULT_LAT = 33;
  localparam int DIV_LAT  = 34;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_PASS = 2'd0,
    BOOTH_ADD  = 2'd1,
    BOOTH_SUB  = 2'd2
  } booth_sel_e;

  // Radix-2 Booth: {lo[0], q_m1} = 01 adds, 10 subtracts, 00/11 pass.
  function automatic booth_sel_e booth_decode(input logic [1:0] bits);
    booth_sel_e sel;
    case (bits)
      2'b01:   sel = BOOTH_ADD;
      2'b10:   sel = BOOTH_SUB;
      default: sel = BOOTH_PASS;
    endcase
    return sel;
  endfunction

  // |x| as an unsigned value; -2^31 maps to 0x80000000, which is exact
  // when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    if (x[WIDTH-1]) begin
      m = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

endpackage

// File: rtl/multdiv_operand_mux.sv
// -----------------------------------------------------------------------------
// multdiv_operand_mux
// Combinational steering of the shared external adder/subtractor.
// Ports:
//   state      in  current sequencer state (multdiv_pkg::state_e encoding)
//   booth_bits in  {lo[0], q_m1} of the multiply register
//   hi         in  multiply high word / division partial remainder
//   lo         in  multiply low word / division quotient register
//   opa        in  multiplicand (MULT) or divisor magnitude (DIV)
//   neg_fix    in  quotient must be negated in the FIX cycle
//   add_a      out adder operand 0
//   add_b      out adder operand 1 (already inverted for subtraction)
//   add_cin    out adder carry-in
// In IDLE and DONE all adder operands are zero.
// -----------------------------------------------------------------------------
module multdiv_operand_mux
  import multdiv_pkg::*;
(
  input  logic [2:0]       state,
  input  logic [1:0]       booth_bits,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opa,
  input  logic             neg_fix,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin
);

  state_e     st_s;
  booth_sel_e sel_s;

  assign st_s  = state_e'(state);
  assign sel_s = booth_decode(booth_bits);

  // Adder operand selection per state.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (st_s)
      ST_MULT: begin
        add_a = hi;
        case (sel_s)
          BOOTH_ADD: begin
            add_b   = opa;
            add_cin = 1'b0;
          end
          BOOTH_SUB: begin
            add_b   = ~opa;
            add_cin = 1'b1;
          end
          default: begin
            add_b   = '0;
            add_cin = 1'b0;
          end
        endcase
      end
      ST_DIV: begin
        // Trial subtraction of the divisor from the shifted remainder R'.
        add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
        add_b   = ~opa;
        add_cin = 1'b1;
      end
      ST_FIX: begin
        if (neg_fix) begin
          add_a   = ~lo;
          add_b   = '0;
          add_cin = 1'b1;
        end else begin
          add_a   = '0;
          add_b   = '0;
          add_cin = 1'b0;
        end
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_seq_ctrl
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes plus one sign-fix cycle) sequencer driving one shared external
// adder per cycle.
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   data_operandA/B       operands, latched on the accepting edge
//   ctrl_MULT / ctrl_DIV  start requests (MULT wins if both), accepted only
//                         in IDLE or DONE
//   data_result           product low word / quotient, updated on DONE entry
//   data_exception        overflow / divide-by-zero / -2^31 / -1
//   data_resultRDY        one-cycle pulse while in DONE
//   busy                  high in MULT, DIV and FIX
//   add_a/add_b/add_cin   shared adder inputs
//   add_sum/cout/ovf      shared adder outputs
// Latency, counting the accepting edge as edge 1: RDY is high after edge 33
// (MULT: 32 Booth steps) or edge 34 (DIV: 32 steps + FIX).
// -----------------------------------------------------------------------------
module multdiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_ovf
);

  import multdiv_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // hi: Booth high word / partial remainder; lo: Booth low word / quotient.
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               qm1_q, qm1_d;
  // opa: multiplicand for MULT, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic               neg_q, neg_d;
  logic               dvz_q, dvz_d;
  logic               dovf_q, dovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               cnt_last_s;
  logic               mult_sign_s;
  logic [WIDTH-1:0]   mult_hi_s;
  logic [WIDTH-1:0]   mult_lo_s;
  logic [WIDTH-1:0]   rem_shift_s;
  logic [WIDTH-1:0]   quo_fix_s;

  assign cnt_last_s = (cnt_q == {CNT_W{1'b1}});

  // Sign of the true 33-bit adder result; stays exact when A = -2^31.
  assign mult_sign_s = add_sum[WIDTH-1] ^ add_ovf;
  assign mult_hi_s   = {mult_sign_s, add_sum[WIDTH-1:1]};
  assign mult_lo_s   = {add_sum[0], lo_q[WIDTH-1:1]};

  assign rem_shift_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign quo_fix_s   = neg_q ? add_sum : lo_q;

  multdiv_operand_mux u_operand_mux (
    .state      (state_q),
    .booth_bits ({lo_q[0], qm1_q}),
    .hi         (hi_q),
    .lo         (lo_q),
    .opa        (opa_q),
    .neg_fix    (neg_q),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin)
  );

  // Next-state, datapath and output register computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    opa_d    = opa_q;
    neg_d    = neg_q;
    dvz_d    = dvz_q;
    dovf_d   = dovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_MULT) begin
          state_d = ST_MULT;
          cnt_d   = '0;
          exc_d   = 1'b0;
          hi_d    = '0;
          lo_d    = data_operandB;
          qm1_d   = 1'b0;
          opa_d   = data_operandA;
        end else if (ctrl_DIV) begin
          state_d = ST_DIV;
          cnt_d   = '0;
          exc_d   = 1'b0;
          hi_d    = '0;
          lo_d    = magnitude(data_operandA);
          qm1_d   = 1'b0;
          opa_d   = magnitude(data_operandB);
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dvz_d   = (data_operandB == {WIDTH{1'b0}});
          dovf_d  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (data_operandB == {WIDTH{1'b1}});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        hi_d  = mult_hi_s;
        lo_d  = mult_lo_s;
        qm1_d = lo_q[0];
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_last_s) begin
          state_d  = ST_DONE;
          result_d = mult_lo_s;
          // Product fits only if the high word is the sign extension of lo.
          exc_d    = (mult_hi_s != {WIDTH{mult_lo_s[WIDTH-1]}});
          rdy_d    = 1'b1;
        end else begin
          state_d  = ST_MULT;
        end
      end
      ST_DIV: begin
        // add_cout=1 means R' >= |B|: keep the difference, quotient bit 1.
        if (add_cout) begin
          hi_d = add_sum;
        end else begin
          hi_d = rem_shift_s;
        end
        lo_d  = {lo_q[WIDTH-2:0], add_cout};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_last_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        rdy_d   = 1'b1;
        exc_d   = dvz_q | dovf_q;
        if (dvz_q) begin
          result_d = '0;
        end else if (dovf_q) begin
          result_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          result_d = quo_fix_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_MULT) || (state_d == ST_DIV) || (state_d == ST_FIX);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      opa_q    <= '0;
      neg_q    <= 1'b0;
      dvz_q    <= 1'b0;
      dovf_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      opa_q    <= opa_d;
      neg_q    <= neg_d;
      dvz_q    <= dvz_d;
      dovf_q   <= dovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_seq_ctrl
// Self-checking bench: table of directed vectors, hand-written multi-cycle
// sequences, and randomized operations against an arithmetic reference model.
// The bench also provides the external adder the sequencer drives.
// -----------------------------------------------------------------------------
module tb_multdiv_seq_ctrl;

  localparam int LAT_MULT = 33;
  localparam int LAT_DIV  = 34;
  localparam int LAT_MAX  = 100;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        add_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  multdiv_seq_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_cin        (add_cin),
    .add_sum        (add_sum),
    .add_cout       (add_cout),
    .add_ovf        (add_ovf)
  );

  // External combinational adder.
  logic [32:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum  = add_full[31:0];
  assign add_cout = add_full[32];
  assign add_ovf  = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition.
  task automatic ref_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc);
    logic signed [63:0] sa, sb, p;
    logic signed [31:0] q;
    if (!is_div) begin
      sa  = $signed(a);
      sb  = $signed(b);
      p   = sa * sb;
      res = p[31:0];
      exc = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      q   = $signed(a) / $signed(b);
      res = q;
      exc = 1'b0;
    end
  endtask

  task automatic start_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
  endtask

  // Edge counting starts at the accepting edge (edge 1).
  task automatic finish_op(output logic [31:0] res, output logic exc, output int lat);
    @(posedge clock);
    lat = 1;
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    while (!data_resultRDY && lat < LAT_MAX) begin
      @(posedge clock);
      lat++;
      #1;
    end
    res = data_result;
    exc = data_exception;
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat);
    @(negedge clock);
    start_op(is_div, a, b);
    finish_op(res, exc, lat);
  endtask

  vec_t        vecs[$];
  logic [31:0] res, eres;
  logic        exc, eexc;
  int          lat, extra_rdy;

  initial begin
    reset         = 1'b1;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc",    {31'd0, data_exception}, 32'd0);
    check("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_add_a",  add_a, 32'd0);
    check("reset_add_b",  add_b, 32'd0);
    check("reset_add_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors.
    vecs.push_back('{"mul_7_m3",      1'b0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{"mul_min_m1",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{"mul_2p16_sq",   1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{"mul_min_1",     1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0});
    vecs.push_back('{"mul_m1_m1",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vecs.push_back('{"div_m100_7",    1'b1, 32'hFFFF_FF9C, 32'h7,         32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{"div_5_0",       1'b1, 32'h5,         32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{"div_min_m1",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{"div_min_2",     1'b1, 32'h8000_0000, 32'h2,         32'hC000_0000, 1'b0});
    vecs.push_back('{"div_100_m7",    1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{"div_3_7",       1'b1, 32'd3,         32'd7,         32'h0000_0000, 1'b0});

    foreach (vecs[i]) begin
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, res, exc, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_exc"}, {31'd0, exc}, {31'd0, vecs[i].exp_exc});
      check({vecs[i].name, "_lat"}, lat, vecs[i].is_div ? LAT_DIV : LAT_MULT);
      @(posedge clock);
      #1;
      check({vecs[i].name, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
      check({vecs[i].name, "_hold"}, data_result, vecs[i].exp_res);
    end

    // Both requests in the same cycle: multiply wins.
    @(negedge clock);
    start_op(1'b0, 32'h7, 32'hFFFF_FFFD);
    ctrl_DIV = 1'b1;
    finish_op(res, exc, lat);
    check("both_res", res, 32'hFFFF_FFEB);
    check("both_lat", lat, LAT_MULT);

    // ctrl_DIV mid-multiply is ignored; only one RDY pulse.
    @(negedge clock);
    start_op(1'b0, 32'h0001_0000, 32'd3);
    @(posedge clock);
    lat = 1;
    #1;
    ctrl_MULT = 1'b0;
    repeat (5) begin
      @(posedge clock);
      lat++;
    end
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    data_operandA = 32'd9;
    data_operandB = 32'd2;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    lat++;
    #1;
    ctrl_DIV = 1'b0;
    while (!data_resultRDY && lat < LAT_MAX) begin
      @(posedge clock);
      lat++;
      #1;
    end
    check("mid_div_res", data_result, 32'h0003_0000);
    check("mid_div_lat", lat, LAT_MULT);
    extra_rdy = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) extra_rdy++;
    end
    check("mid_div_single_rdy", extra_rdy, 0);

    // Back-to-back: new start issued in the DONE cycle.
    run_op(1'b0, 32'd6, 32'd7, res, exc, lat);
    check("b2b_first_res", res, 32'd42);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    finish_op(res, exc, lat);
    check("b2b_second_res", res, 32'hFFFF_FFF2);
    check("b2b_second_lat", lat, LAT_DIV);
    start_op(1'b0, 32'd5, 32'hFFFF_FFFF);
    finish_op(res, exc, lat);
    check("b2b_third_res", res, 32'hFFFF_FFFB);
    check("b2b_third_lat", lat, LAT_MULT);

    // Reset at cycle 10 of a divide aborts it.
    @(negedge clock);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    @(posedge clock);
    lat = 1;
    #1;
    ctrl_DIV = 1'b0;
    while (lat < 10) begin
      @(posedge clock);
      lat++;
    end
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_result", data_result, 32'd0);
    check("rst_mid_exc",  {31'd0, data_exception}, 32'd0);
    check("rst_mid_rdy",  {31'd0, data_resultRDY}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_add",  add_a | add_b | {31'd0, add_cin}, 32'd0);
    reset = 1'b0;
    extra_rdy = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) extra_rdy++;
    end
    check("rst_mid_no_rdy", extra_rdy, 0);
    run_op(1'b0, 32'd3, 32'd4, res, exc, lat);
    check("rst_then_mul_res", res, 32'd12);
    check("rst_then_mul_exc", {31'd0, exc}, 32'd0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic        is_div;
      logic [31:0] a, b;
      is_div = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 2000) - 1000; end
        2: begin a = $urandom; b = (is_div ? 32'd0 : 32'h8000_0000); end
        default: begin a = $urandom; b = $urandom_range(0, 64) - 32; end
      endcase
      ref_op(is_div, a, b, eres, eexc);
      run_op(is_div, a, b, res, exc, lat);
      check($sformatf("rand%0d_res", k), res, eres);
      check($sformatf("rand%0d_exc", k), {31'd0, exc}, {31'd0, eexc});
      check($sformatf("rand%0d_lat", k), lat, is_div ? LAT_DIV : LAT_MULT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
